// File: rtl/spm_pkg.sv
// Shared types and sizing for the serial-parallel multiplier sequencer.
package spm_pkg;

   localparam int unsigned WIDTH_DEFAULT = 8;
   localparam int unsigned PROD_W        = 2 * WIDTH_DEFAULT;
   localparam int unsigned CNT_W         = $clog2(PROD_W);

   typedef enum logic [1:0] {
      IDLE,
      CLEAR,
      RUN,
      DONE
   } state_e;

endpackage

// File: rtl/spm_prod_collector.sv
// Right-shift register assembling the serial product, LSB emerging first from the core.
module spm_prod_collector
   import spm_pkg::*;
#(
   parameter int unsigned PW = PROD_W
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          shift_en,
   input  logic          bit_in,
   output logic [PW-1:0] prod
);

   // New bits enter at the MSB so bit k settles at position k after PW shifts.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         prod <= '0;
      end else if (shift_en) begin
         prod <= {bit_in, prod[PW-1:1]};
      end
   end

endmodule

// File: rtl/spm_ctrl.sv
// Sequencer for the SPM core: latches operands, streams the sign-extended multiplier and
// collects the serial product into a registered 2*WIDTH-bit result.
module spm_ctrl
   import spm_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   multiplier,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] product,
   output logic               spm_clr,
   output logic [WIDTH-1:0]   spm_mcand,
   output logic               spm_mplier_bit,
   input  logic               spm_p_bit
);

   localparam int unsigned PW = 2 * WIDTH;
   localparam int unsigned CW = $clog2(PW);

   state_e           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0] mplier_q;
   logic             clr_q;
   logic [PW-1:0]    mplier_ext;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         clr_q     <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  mcand_q  <= multiplicand;
                  mplier_q <= multiplier;
                  in_ready <= 1'b0;
                  clr_q    <= 1'b1;
                  state    <= CLEAR;
               end
            end
            CLEAR: begin
               cnt   <= '0;
               clr_q <= 1'b0;
               state <= RUN;
            end
            RUN: begin
               if (cnt == CW'(PW - 1)) begin
                  cnt       <= '0;
                  out_valid <= 1'b1;
                  clr_q     <= 1'b1;
                  state     <= DONE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  clr_q     <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Upper half repeats the sign bit so the core sees the multiplier sign-extended.
   assign mplier_ext     = {{WIDTH{mplier_q[WIDTH-1]}}, mplier_q};
   assign spm_mplier_bit = (state == RUN) && mplier_ext[cnt];
   assign spm_mcand      = mcand_q;
   assign spm_clr        = clr_q || rst;

   spm_prod_collector #(
      .PW(PW)
   ) u_collector (
      .clk     (clk),
      .rst     (rst),
      .clr     (state == CLEAR),
      .shift_en(state == RUN),
      .bit_in  (spm_p_bit),
      .prod    (product)
   );

endmodule

// File: tb/tb_spm_ctrl.sv
// Bench for spm_ctrl: behavioural SPM core, scoreboard of expected products, latency checks.
module tb_spm_ctrl;

   localparam int W = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  mc, mp;
   logic          out_valid;
   logic          out_ready;
   logic [2*W-1:0] product;
   logic          spm_clr;
   logic [W-1:0]  spm_mcand;
   logic          spm_mplier_bit;
   logic          spm_p_bit;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   logic [2*W-1:0] exp_cur;
   logic [2*W-1:0] exp_q[$];
   int             acc_q[$];
   bit             spacing_on = 0;
   bit             have_prev  = 0;
   int             prev_acc   = 0;
   bit             ov_prev    = 0;
   bit             ok;

   spm_ctrl #(.WIDTH(W)) dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .multiplicand  (mc),
      .multiplier    (mp),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .product       (product),
      .spm_clr       (spm_clr),
      .spm_mcand     (spm_mcand),
      .spm_mplier_bit(spm_mplier_bit),
      .spm_p_bit     (spm_p_bit)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural core: shift-add accumulator emitting one product bit per cycle.
   logic signed [2*W+1:0] core_acc = '0;
   logic signed [2*W+1:0] core_sum;
   assign core_sum  = core_acc + (spm_mplier_bit ? {{(W+2){spm_mcand[W-1]}}, spm_mcand}
                                                 : '0);
   assign spm_p_bit = core_sum[0];
   always @(posedge clk) core_acc <= spm_clr ? '0 : (core_sum >>> 1);

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Monitor: pushes on accept, pops and compares on output handshake.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (in_valid && in_ready) begin
               exp_q.push_back(exp_cur);
               acc_q.push_back(cyc);
               if (spacing_on && have_prev) check("accept_spacing", 64'(cyc - prev_acc), 19);
               prev_acc  = cyc;
               have_prev = 1;
            end
            if (out_valid && !ov_prev) begin
               if (acc_q.size() > 0) check("latency", 64'(cyc - acc_q.pop_front()), 18);
               else check("latency_orphan", 64'(out_valid), 0);
            end
            if (out_valid && out_ready) begin
               if (exp_q.size() > 0) check("product", 64'(product), 64'(exp_q.pop_front()));
               else check("product_orphan", 64'(out_valid), 0);
            end
         end
         ov_prev = out_valid;
      end
   end

   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] e, input bit keep);
      @(posedge clk); #1;
      in_valid = 1'b1;
      mc       = a;
      mp       = b;
      exp_cur  = e;
      ok       = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (in_ready) begin ok = 1; break; end
      end
      if (!ok) check("accept_timeout", 64'(in_ready), 1);
      @(posedge clk); #1;
      if (!keep) begin
         in_valid = 1'b0;
         mc       = W'($urandom);
         mp       = W'($urandom);
      end
   endtask

   task automatic wait_ov();
      ok = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (out_valid) begin ok = 1; break; end
      end
      if (!ok) check("out_valid_timeout", 64'(out_valid), 1);
   endtask

   task automatic wait_idle();
      ok = 0;
      for (int i = 0; i < 120; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && in_ready && !out_valid) begin ok = 1; break; end
      end
      if (!ok) check("idle_timeout", 64'(exp_q.size()), 0);
   endtask

   initial begin
      logic signed [W-1:0]   ra, rb;
      logic signed [2*W-1:0] rp;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; mc = '0; mp = '0; exp_cur = '0;

      // Reset
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("clr_during_reset", 64'(spm_clr), 1);
      check("out_valid_in_reset", 64'(out_valid), 0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("in_ready_after_reset", 64'(in_ready), 1);
      check("out_valid_after_reset", 64'(out_valid), 0);
      check("product_after_reset", 64'(product), 0);
      check("clr_idle", 64'(spm_clr), 0);

      // Basic 5 x 3
      do_op(8'd5, 8'd3, 16'h000F, 0);
      wait_ov();
      check("basic_product", 64'(product), 16'h000F);
      @(negedge clk);
      check("single_cycle_valid", 64'(out_valid), 0);
      wait_idle();

      // Signed corners
      do_op(8'hFF, 8'hFF, 16'h0001, 0); wait_idle();
      do_op(8'h80, 8'h80, 16'h4000, 0); wait_idle();
      do_op(8'h80, 8'h7F, 16'hC080, 0); wait_idle();
      do_op(8'h00, 8'hB3, 16'h0000, 0); wait_idle();

      // Backpressure
      out_ready = 1'b0;
      do_op(8'd7, 8'hFE, 16'hFFF2, 0);
      wait_ov();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp_out_valid", 64'(out_valid), 1);
         check("bp_product", 64'(product), 16'hFFF2);
         check("bp_in_ready", 64'(in_ready), 0);
      end
      @(posedge clk); #1 out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("bp_release_in_ready", 64'(in_ready), 1);
      check("bp_release_out_valid", 64'(out_valid), 0);

      // Reset during RUN at k=5
      do_op(8'd100, 8'd100, 16'h2710, 0);
      repeat (6) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check("clr_mid_reset", 64'(spm_clr), 1);
      @(posedge clk); #1 rst = 1'b0;
      exp_q.delete();
      acc_q.delete();
      @(negedge clk);
      check("abort_out_valid", 64'(out_valid), 0);
      check("abort_in_ready", 64'(in_ready), 1);
      check("abort_product", 64'(product), 0);
      do_op(8'd2, 8'd2, 16'h0004, 0);
      wait_ov();
      check("post_abort_product", 64'(product), 16'h0004);
      wait_idle();

      // Back-to-back with in_valid held high
      spacing_on = 1; have_prev = 0;
      for (int i = 0; i < 4; i++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         rp = ra * rb;
         do_op(ra, rb, rp, 1);
      end
      in_valid = 1'b0;
      wait_idle();
      spacing_on = 0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
